// File: rtl/k2_uart_tx_arbiter_if.sv
// Bundle of requester, UART and status signals around the K2 UART transmit arbiter.
// master: the requesters / UART / software side. slave: the arbiter itself.
interface k2_uart_tx_arbiter_if #(
    parameter int Bits  = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            req0_valid;
    logic [Bits-1:0] req0_data;
    logic            req0_ready;
    logic            req1_valid;
    logic [Bits-1:0] req1_data;
    logic            req1_ready;
    logic            tx_idle;
    logic            start_send;
    logic [Bits-1:0] send_msg_content;
    logic            grant_id;
    logic            busy;
    logic [CW-1:0]   fifo0_count;
    logic [CW-1:0]   fifo1_count;
    logic            clr_err;
    logic            err_timeout;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_idle, clr_err,
        input  req0_ready, req1_ready, start_send, send_msg_content, grant_id,
               busy, fifo0_count, fifo1_count, err_timeout
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_idle, clr_err,
        output req0_ready, req1_ready, start_send, send_msg_content, grant_id,
               busy, fifo0_count, fifo1_count, err_timeout
    );
endinterface

// File: rtl/k2_uart_tx_arbiter.sv
// Shares one UART transmitter between two byte sources. Each source has a small FIFO;
// a round-robin FSM pops one byte, pulses start_send and holds the byte until the
// UART finishes the frame, abandoning it if the UART never acknowledges.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a queued byte and an idle UART; pops on entry to ISSUE
// ISSUE     | start_send high for this single cycle
// WAIT_BUSY | waiting for tx_idle to fall; ack timer counts down to zero
// WAIT_DONE | frame in progress; waiting for tx_idle to rise again
module k2_uart_tx_arbiter #(
    parameter int Bits        = 8,
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input logic                  clk,
    input logic                  rst,
    k2_uart_tx_arbiter_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    logic [Bits-1:0] mem [2][DEPTH];
    logic [PW-1:0]   wr_ptr [2];
    logic [PW-1:0]   rd_ptr [2];
    logic [CW-1:0]   cnt [2];
    logic [Bits-1:0] din [2];
    logic [1:0]      push;
    logic [1:0]      pop;
    logic [1:0]      not_empty;

    state_t          state;
    logic [TW-1:0]   timer;
    logic            last_grant;
    logic            sel;
    logic            do_pop;
    logic [Bits-1:0] head;

    logic            start_send_q;
    logic [Bits-1:0] msg_q;
    logic            grant_q;
    logic            busy_q;
    logic            err_q;

    assign din[0] = bus.req0_data;
    assign din[1] = bus.req1_data;

    // Ready is forced low during reset so nothing is accepted while the FIFOs clear.
    assign bus.req0_ready = !rst && (cnt[0] != CW'(DEPTH));
    assign bus.req1_ready = !rst && (cnt[1] != CW'(DEPTH));

    assign push[0] = bus.req0_valid && bus.req0_ready;
    assign push[1] = bus.req1_valid && bus.req1_ready;

    assign not_empty[0] = (cnt[0] != '0);
    assign not_empty[1] = (cnt[1] != '0);

    // Round-robin source selection and pop decision for the IDLE state.
    always_comb begin
        sel = not_empty[1];
        if (not_empty[0] && not_empty[1]) begin
            sel = ~last_grant;
        end
        do_pop = (state == IDLE) && bus.tx_idle && (|not_empty);
        pop    = {do_pop && sel, do_pop && !sel};
        head   = sel ? mem[1][rd_ptr[1]] : mem[0][rd_ptr[0]];
    end

    // FIFO storage; push is already gated off during reset through ready.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= din[i];
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                if (push[i] && !pop[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (!push[i] && pop[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // Arbitration FSM with registered UART-facing outputs and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            last_grant   <= 1'b1;
            start_send_q <= 1'b0;
            msg_q        <= '0;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // A timeout in the same cycle overrides this clear below.
            if (bus.clr_err) begin
                err_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (do_pop) begin
                        msg_q        <= head;
                        grant_q      <= sel;
                        start_send_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_send_q <= 1'b0;
                    timer        <= TW'(ACK_TIMEOUT - 1);
                    state        <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!bus.tx_idle) begin
                        state <= WAIT_DONE;
                    end else if (timer == '0) begin
                        err_q      <= 1'b1;
                        last_grant <= grant_q;
                        busy_q     <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.tx_idle) begin
                        last_grant <= grant_q;
                        busy_q     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_send       = start_send_q;
    assign bus.send_msg_content = msg_q;
    assign bus.grant_id         = grant_q;
    assign bus.busy             = busy_q;
    assign bus.err_timeout      = err_q;
    assign bus.fifo0_count      = cnt[0];
    assign bus.fifo1_count      = cnt[1];
endmodule

// File: tb/tb_k2_uart_tx_arbiter.sv
// Self-checking bench for k2_uart_tx_arbiter: a table of FIFO push vectors plus
// hand-written sequences for latency, round robin, timeout, push/pop and reset.
module tb_k2_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    k2_uart_tx_arbiter_if #(.Bits(8), .DEPTH(4)) bus ();

    k2_uart_tx_arbiter #(.Bits(8), .DEPTH(4), .ACK_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       r0;
        logic       r1;
        logic [2:0] c0;
        logic [2:0] c1;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] sent [$];
    logic [8:0] exp_q [$];
    bit         model_en = 1'b0;
    int         busy_len = 2;
    int         uart_cnt = 0;
    bit         prev_start = 1'b0;
    int         pulse_err = 0;
    vec_t       tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: sample after the edge, log issued bytes, advance the UART model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.start_send) begin
            sent.push_back({bus.grant_id, bus.send_msg_content});
            if (prev_start) pulse_err++;
            if (model_en) uart_cnt = busy_len;
        end
        prev_start = bus.start_send;
        if (model_en) begin
            if (uart_cnt > 0) begin
                bus.tx_idle = 1'b0;
                uart_cnt--;
            end else begin
                bus.tx_idle = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.clr_err    = 1'b0;
        model_en       = 1'b0;
        uart_cnt       = 0;
        bus.tx_idle    = 1'b1;
        rst            = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (!(!bus.busy && bus.fifo0_count == 0 && bus.fifo1_count == 0) && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_drain_bound"}, int'(n < 300), 1);
    endtask

    task automatic check_sent(input string name);
        chk({name, "_nbytes"}, sent.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", name, i),
                (i < sent.size()) ? int'(sent[i]) : -1, int'(exp_q[i]));
        end
    endtask

    initial begin
        //          v0  d0     v1  d1     r0  r1  c0  c1
        tbl[0] = '{1'b1, 8'h31, 1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 3'd0};
        tbl[1] = '{1'b1, 8'h32, 1'b1, 8'h41, 1'b1, 1'b1, 3'd2, 3'd1};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 3'd1};
        tbl[3] = '{1'b1, 8'h34, 1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 3'd1};
        tbl[4] = '{1'b1, 8'h35, 1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 3'd1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 8'h42, 1'b0, 1'b1, 3'd4, 3'd2};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 3'd2};

        bus.req0_valid = 1'b0;
        bus.req0_data  = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_data  = 8'h00;
        bus.clr_err    = 1'b0;
        bus.tx_idle    = 1'b1;

        // Reset state while rst is still high.
        rst = 1'b1;
        tick();
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        chk("rst_count0", bus.fifo0_count, 0);
        chk("rst_count1", bus.fifo1_count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_start", bus.start_send, 0);
        chk("rst_msg", bus.send_msg_content, 0);
        chk("rst_grant", bus.grant_id, 0);
        chk("rst_err", bus.err_timeout, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready0", bus.req0_ready, 1);

        // Single byte: latency, pulse width and busy release.
        do_reset();
        model_en = 1'b1;
        busy_len = 2;
        sent.delete();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hA5;
        tick();
        bus.req0_valid = 1'b0;
        chk("t1_start_n", bus.start_send, 0);
        chk("t1_count_n", bus.fifo0_count, 1);
        tick();
        chk("t1_start", bus.start_send, 1);
        chk("t1_msg", bus.send_msg_content, 8'hA5);
        chk("t1_grant", bus.grant_id, 0);
        chk("t1_busy", bus.busy, 1);
        chk("t1_count_pop", bus.fifo0_count, 0);
        tick();
        chk("t1_start_low", bus.start_send, 0);
        tick();
        chk("t1_busy_wait", bus.busy, 1);
        tick();
        chk("t1_busy_fall", bus.busy, 0);
        chk("t1_msg_hold", bus.send_msg_content, 8'hA5);

        // Table: fill FIFOs with the UART held busy, then release and check order.
        do_reset();
        bus.tx_idle = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.req0_valid = tbl[i].v0;
            bus.req0_data  = tbl[i].d0;
            bus.req1_valid = tbl[i].v1;
            bus.req1_data  = tbl[i].d1;
            tick();
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            chk($sformatf("tbl%0d_count0", i), bus.fifo0_count, tbl[i].c0);
            chk($sformatf("tbl%0d_count1", i), bus.fifo1_count, tbl[i].c1);
            chk($sformatf("tbl%0d_ready0", i), bus.req0_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_ready1", i), bus.req1_ready, tbl[i].r1);
            chk($sformatf("tbl%0d_busy", i), bus.busy, 0);
        end
        exp_q = '{9'h031, 9'h141, 9'h032, 9'h142, 9'h033, 9'h034};
        sent.delete();
        model_en    = 1'b1;
        busy_len    = 2;
        bus.tx_idle = 1'b1;
        drain("tbl");
        check_sent("tbl");

        // Round robin on two preloaded FIFOs.
        do_reset();
        bus.tx_idle    = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = 8'h11;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h21;
        tick();
        bus.req0_data = 8'h12;
        bus.req1_data = 8'h22;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        exp_q = '{9'h011, 9'h121, 9'h012, 9'h122};
        sent.delete();
        model_en    = 1'b1;
        busy_len    = 3;
        bus.tx_idle = 1'b1;
        drain("rr");
        check_sent("rr");

        // Push and pop in the same cycle at count 3.
        do_reset();
        bus.tx_idle    = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data = 8'h61; tick();
        bus.req0_data = 8'h62; tick();
        bus.req0_data = 8'h63; tick();
        chk("pp_count_pre", bus.fifo0_count, 3);
        bus.req0_data = 8'h64;
        sent.delete();
        model_en    = 1'b1;
        busy_len    = 2;
        bus.tx_idle = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        chk("pp_count_same", bus.fifo0_count, 3);
        chk("pp_start", bus.start_send, 1);
        chk("pp_msg", bus.send_msg_content, 8'h61);
        exp_q = '{9'h061, 9'h062, 9'h063, 9'h064};
        drain("pp");
        check_sent("pp");

        // Ack timeout with tx_idle stuck high, clear, and set-wins-over-clear.
        do_reset();
        bus.tx_idle    = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data = 8'h51; tick();
        bus.req0_data = 8'h52; tick();
        bus.req0_valid = 1'b0;
        bus.tx_idle    = 1'b1;
        tick();
        chk("to_start1", bus.start_send, 1);
        chk("to_msg1", bus.send_msg_content, 8'h51);
        tick();
        chk("to_start1_low", bus.start_send, 0);
        repeat (15) tick();
        chk("to_err_before", bus.err_timeout, 0);
        chk("to_busy_before", bus.busy, 1);
        tick();
        chk("to_err_set", bus.err_timeout, 1);
        chk("to_busy_drop", bus.busy, 0);
        tick();
        chk("to_start2", bus.start_send, 1);
        chk("to_msg2", bus.send_msg_content, 8'h52);
        chk("to_grant2", bus.grant_id, 0);
        bus.clr_err = 1'b1;
        tick();
        chk("to_err_clr", bus.err_timeout, 0);
        repeat (15) tick();
        chk("to_err_still_clr", bus.err_timeout, 0);
        tick();
        chk("to_set_wins", bus.err_timeout, 1);
        bus.clr_err = 1'b0;
        tick();
        chk("to_err_sticky", bus.err_timeout, 1);
        chk("to_idle_empty", bus.busy, 0);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("to_err_clr2", bus.err_timeout, 0);

        // Reset in WAIT_DONE with both FIFOs holding data.
        do_reset();
        bus.tx_idle    = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = 8'h71;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h81;
        tick();
        bus.req1_valid = 1'b0;
        bus.req0_data  = 8'h72;
        tick();
        bus.req0_valid = 1'b0;
        model_en    = 1'b1;
        busy_len    = 6;
        bus.tx_idle = 1'b1;
        tick();
        chk("rw_start", bus.start_send, 1);
        tick();
        tick();
        chk("rw_busy", bus.busy, 1);
        chk("rw_count0", bus.fifo0_count, 1);
        chk("rw_count1", bus.fifo1_count, 1);
        rst = 1'b1;
        tick();
        chk("rw_rst_count0", bus.fifo0_count, 0);
        chk("rw_rst_count1", bus.fifo1_count, 0);
        chk("rw_rst_busy", bus.busy, 0);
        chk("rw_rst_start", bus.start_send, 0);
        chk("rw_rst_err", bus.err_timeout, 0);
        chk("rw_rst_ready0", bus.req0_ready, 0);
        rst         = 1'b0;
        model_en    = 1'b0;
        uart_cnt    = 0;
        bus.tx_idle = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h99;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        chk("rw_after_start", bus.start_send, 1);
        chk("rw_after_grant", bus.grant_id, 0);
        chk("rw_after_msg", bus.send_msg_content, 8'h99);

        chk("start_pulse_width", pulse_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
